// File: rtl/kb_scr_fifo_drv_pkg.sv
// CSR bit positions and TX handshake state encodings shared by the kb/screen driver.
package kb_scr_fifo_drv_pkg;

    localparam int unsigned CSR_ENA = 4;
    localparam int unsigned CSR_OF  = 3;
    localparam int unsigned CSR_DBA = 2;
    localparam int unsigned CSR_IO  = 1;
    localparam int unsigned CSR_IE  = 0;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_ACK  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/dev_fifo.sv
// Synchronous FIFO: registered pointers, combinational head (zero when empty).
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module dev_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DATA_W-1:0]        i_dat,
    output logic [DATA_W-1:0]        o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_CNT);
    assign o_count   = r_count;
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    // Power-of-two depth lets the pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/kb_scr_fifo_drv.sv
// Buffered keyboard (RX) / screen (TX) driver with sticky overflow flags and a 4-phase TX handshake.
// Optional interrupts when KB_SCR_IRQ_EN is defined; otherwise kb_irq/scr_irq are tied low.
module kb_scr_fifo_drv
    import kb_scr_fifo_drv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        CSR_kb_i,
    input  logic [7:0]        CSR_scr_i,
    output logic [7:0]        CSR_kb_o,
    output logic [7:0]        CSR_scr_o,
    output logic [DATA_W-1:0] data_reg_kb,
    input  logic              kb_pop,
    input  logic              kb_of_clr,
    input  logic [DATA_W-1:0] data_reg_scr,
    input  logic              scr_push,
    input  logic              scr_of_clr,
    input  logic [DATA_W-1:0] data_bus_i,
    output logic [DATA_W-1:0] data_bus_o,
    input  logic [1:0]        control_i,
    output logic [1:0]        control_o,
    output logic              kb_irq,
    output logic              scr_irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic              w_kb_full, w_kb_empty, w_kb_wr, w_kb_pop_ok, w_kb_acc, w_kb_ovf;
    logic              w_scr_full, w_scr_empty, w_scr_wr, w_scr_ovf;
    logic [DATA_W-1:0] w_scr_head;
    logic [CW-1:0]     w_kb_count, w_scr_count;
    logic              w_kb_dba, w_scr_dba;

    logic              r_kb_of, r_scr_of, r_write_ok_n;
    tx_state_t         r_state, w_nxt_state;
    logic [DATA_W-1:0] r_data_bus_o, w_nxt_dat;
    logic              r_read_en_n, w_nxt_rd_n, w_tx_pop;

    assign w_kb_wr     = control_i[1] & CSR_kb_i[CSR_ENA];
    assign w_kb_pop_ok = kb_pop & ~w_kb_empty;
    assign w_kb_acc    = w_kb_wr & (~w_kb_full | w_kb_pop_ok);
    assign w_kb_ovf    = w_kb_wr & w_kb_full & ~w_kb_pop_ok;

    assign w_scr_wr    = scr_push & CSR_scr_i[CSR_ENA];
    assign w_scr_ovf   = w_scr_wr & w_scr_full & ~w_tx_pop;

    dev_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_kb_wr),
        .i_pop   (kb_pop),
        .i_dat   (data_bus_i),
        .o_head  (data_reg_kb),
        .o_full  (w_kb_full),
        .o_empty (w_kb_empty),
        .o_count (w_kb_count)
    );

    dev_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_scr_wr),
        .i_pop   (w_tx_pop),
        .i_dat   (data_reg_scr),
        .o_head  (w_scr_head),
        .o_full  (w_scr_full),
        .o_empty (w_scr_empty),
        .o_count (w_scr_count)
    );

    assign w_kb_dba  = ~w_kb_empty;
    assign w_scr_dba = ~w_scr_full;

    // New overflow beats a same-cycle clear so no drop goes unreported.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kb_of      <= 1'b0;
            r_scr_of     <= 1'b0;
            r_write_ok_n <= 1'b1;
        end else begin
            r_write_ok_n <= ~w_kb_acc;
            if (w_kb_ovf) begin
                r_kb_of <= 1'b1;
            end else if (kb_of_clr) begin
                r_kb_of <= 1'b0;
            end
            if (w_scr_ovf) begin
                r_scr_of <= 1'b1;
            end else if (scr_of_clr) begin
                r_scr_of <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= TX_IDLE;
            r_data_bus_o <= '0;
            r_read_en_n  <= 1'b1;
        end else begin
            r_state      <= w_nxt_state;
            r_data_bus_o <= w_nxt_dat;
            r_read_en_n  <= w_nxt_rd_n;
        end
    end

    // Head stays in the FIFO until the device acks, so a full FIFO stays full through SEND.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_dat   = r_data_bus_o;
        w_nxt_rd_n  = r_read_en_n;
        w_tx_pop    = 1'b0;
        unique case (r_state)
            TX_IDLE: begin
                if (CSR_scr_i[CSR_ENA] && !w_scr_empty) begin
                    w_nxt_dat   = w_scr_head;
                    w_nxt_rd_n  = 1'b0;
                    w_nxt_state = TX_SEND;
                end
            end
            TX_SEND: begin
                if (control_i[0]) begin
                    w_tx_pop    = 1'b1;
                    w_nxt_rd_n  = 1'b1;
                    w_nxt_state = TX_ACK;
                end
            end
            TX_ACK: begin
                if (!control_i[0]) begin
                    w_nxt_state = TX_IDLE;
                end
            end
            default: begin
                w_nxt_state = TX_IDLE;
                w_nxt_rd_n  = 1'b1;
            end
        endcase
    end

    assign data_bus_o = r_data_bus_o;
    assign control_o  = {r_read_en_n, r_write_ok_n};
    assign CSR_kb_o   = {CSR_kb_i[7:4], r_kb_of, w_kb_dba, CSR_kb_i[1:0]};
    assign CSR_scr_o  = {CSR_scr_i[7:4], r_scr_of, w_scr_dba, CSR_scr_i[1:0]};

`ifdef KB_SCR_IRQ_EN
    logic r_kb_irq, r_scr_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kb_irq  <= 1'b0;
            r_scr_irq <= 1'b0;
        end else begin
            r_kb_irq  <= CSR_kb_i[CSR_ENA] & CSR_kb_i[CSR_IE] & w_kb_dba;
            r_scr_irq <= CSR_scr_i[CSR_ENA] & CSR_scr_i[CSR_IE] & w_scr_dba;
        end
    end

    assign kb_irq  = r_kb_irq;
    assign scr_irq = r_scr_irq;
`else
    assign kb_irq  = 1'b0;
    assign scr_irq = 1'b0;
`endif

    logic w_unused;
    assign w_unused = ^{CSR_kb_i[3:2], CSR_scr_i[3:2], w_kb_count, w_scr_count};

endmodule

// File: tb/tb_kb_scr_fifo_drv.sv
// Directed bench for kb_scr_fifo_drv: stimulus pushes expected bytes into queues,
// negedge monitors pop and compare on CPU kb reads and device TX acks.
module tb_kb_scr_fifo_drv;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] CSR_kb_i, CSR_scr_i, CSR_kb_o, CSR_scr_o;
    logic [7:0] data_reg_kb, data_reg_scr, data_bus_i, data_bus_o;
    logic       kb_pop, kb_of_clr, scr_push, scr_of_clr, kb_irq, scr_irq;
    logic [1:0] control_i, control_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] kb_exp [$];
    logic [7:0] tx_exp [$];

    kb_scr_fifo_drv #(.DATA_W(8), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .CSR_kb_i     (CSR_kb_i),
        .CSR_scr_i    (CSR_scr_i),
        .CSR_kb_o     (CSR_kb_o),
        .CSR_scr_o    (CSR_scr_o),
        .data_reg_kb  (data_reg_kb),
        .kb_pop       (kb_pop),
        .kb_of_clr    (kb_of_clr),
        .data_reg_scr (data_reg_scr),
        .scr_push     (scr_push),
        .scr_of_clr   (scr_of_clr),
        .data_bus_i   (data_bus_i),
        .data_bus_o   (data_bus_o),
        .control_i    (control_i),
        .control_o    (control_o),
        .kb_irq       (kb_irq),
        .scr_irq      (scr_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // CPU reads of the keyboard head.
    always @(negedge clk) begin
        if (!rst && kb_pop && CSR_kb_o[2]) begin
            if (kb_exp.size() == 0) chk("kb_unexpected_pop", 32'd1, 32'd0);
            else chk("kb_data", {24'd0, data_reg_kb}, {24'd0, kb_exp.pop_front()});
        end
    end

    // Device acking a screen byte.
    always @(negedge clk) begin
        if (!rst && !control_o[1] && control_i[0]) begin
            if (tx_exp.size() == 0) chk("tx_unexpected_byte", 32'd1, 32'd0);
            else chk("tx_data", {24'd0, data_bus_o}, {24'd0, tx_exp.pop_front()});
        end
    end

    task automatic dev_write(input logic [7:0] d, input bit acc);
        data_bus_i   = d;
        control_i[1] = 1'b1;
        tick();
        control_i[1] = 1'b0;
        if (acc) kb_exp.push_back(d);
        chk("wr_ack", {31'd0, control_o[0]}, {31'd0, !acc});
        tick();
        chk("wr_ack_release", {31'd0, control_o[0]}, 32'd1);
    endtask

    task automatic cpu_pop();
        kb_pop = 1'b1;
        tick();
        kb_pop = 1'b0;
    endtask

    task automatic cpu_push(input logic [7:0] d, input bit acc);
        data_reg_scr = d;
        scr_push     = 1'b1;
        tick();
        scr_push     = 1'b0;
        if (acc) tx_exp.push_back(d);
    endtask

    task automatic wait_send();
        int i;
        for (i = 0; i < 20 && control_o[1]; i++) tick();
        if (control_o[1]) chk("tx_send_timeout", 32'd1, 32'd0);
    endtask

    task automatic dev_ack();
        wait_send();
        control_i[0] = 1'b1;
        tick();
        chk("tx_read_en_release", {31'd0, control_o[1]}, 32'd1);
        tick();
        chk("tx_no_back_to_back", {31'd0, control_o[1]}, 32'd1);
        control_i[0] = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; CSR_kb_i = '0; CSR_scr_i = '0; kb_pop = 0; kb_of_clr = 0;
        data_reg_scr = '0; scr_push = 0; scr_of_clr = 0; data_bus_i = '0; control_i = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1: reset / idle
        chk("rst_csr_kb", {24'd0, CSR_kb_o}, 32'h00);
        chk("rst_csr_scr", {24'd0, CSR_scr_o}, 32'h04);
        chk("rst_control_o", {30'd0, control_o}, 32'h3);
        chk("rst_data_reg_kb", {24'd0, data_reg_kb}, 32'h00);
        chk("rst_data_bus_o", {24'd0, data_bus_o}, 32'h00);
        chk("rst_irqs", {30'd0, kb_irq, scr_irq}, 32'd0);

        // 2: two device bytes, then drained by the CPU
        CSR_kb_i = 8'hD2;
        dev_write(8'h41, 1);
        dev_write(8'h42, 1);
        chk("kb_csr_merge", {24'd0, CSR_kb_o}, 32'hD6);
        chk("kb_head_first", {24'd0, data_reg_kb}, 32'h41);
        cpu_pop();
        chk("kb_head_second", {24'd0, data_reg_kb}, 32'h42);
        cpu_pop();
        chk("kb_dba_empty", {31'd0, CSR_kb_o[2]}, 32'd0);
        chk("kb_head_empty", {24'd0, data_reg_kb}, 32'h00);
        cpu_pop();
        chk("kb_pop_on_empty", {24'd0, CSR_kb_o}, 32'hD2);

        // 3: overflow, clear racing a new overflow, disabled device
        CSR_kb_i = 8'h10;
        for (int i = 1; i <= 5; i++) dev_write(8'(i), i <= 4);
        chk("kb_of_set", {31'd0, CSR_kb_o[3]}, 32'd1);
        kb_of_clr = 1'b1; control_i[1] = 1'b1; data_bus_i = 8'h06;
        tick();
        kb_of_clr = 1'b0; control_i[1] = 1'b0;
        chk("kb_of_clr_vs_ovf", {31'd0, CSR_kb_o[3]}, 32'd1);
        kb_of_clr = 1'b1;
        tick();
        kb_of_clr = 1'b0;
        chk("kb_of_cleared", {31'd0, CSR_kb_o[3]}, 32'd0);
        repeat (4) cpu_pop();
        chk("kb_drained", {31'd0, CSR_kb_o[2]}, 32'd0);
        CSR_kb_i = 8'h00;
        dev_write(8'h77, 0);
        chk("kb_ena0_ignored", {24'd0, CSR_kb_o}, 32'h00);

        // 4: single screen byte through the 4-phase handshake
        CSR_scr_i = 8'h10;
        cpu_push(8'h55, 1);
        wait_send();
        chk("tx_data_valid", {24'd0, data_bus_o}, 32'h55);
        tick();
        chk("tx_hold_en", {31'd0, control_o[1]}, 32'd0);
        chk("tx_hold_data", {24'd0, data_bus_o}, 32'h55);
        dev_ack();
        chk("tx_idle_control", {30'd0, control_o}, 32'h3);

        // 5: push into a full TX FIFO while the device pops, then a true overflow
        for (int i = 1; i <= 4; i++) cpu_push(8'hA0 + 8'(i), 1);
        chk("scr_full_dba", {31'd0, CSR_scr_o[2]}, 32'd0);
        data_reg_scr = 8'hA5; scr_push = 1'b1; control_i[0] = 1'b1;
        tick();
        scr_push = 1'b0; control_i[0] = 1'b0;
        tx_exp.push_back(8'hA5);
        chk("scr_of_simul", {31'd0, CSR_scr_o[3]}, 32'd0);
        cpu_push(8'hA6, 0);
        chk("scr_of_set", {31'd0, CSR_scr_o[3]}, 32'd1);
        repeat (4) dev_ack();
        scr_of_clr = 1'b1;
        tick();
        scr_of_clr = 1'b0;
        chk("scr_csr_after", {24'd0, CSR_scr_o}, 32'h14);

        // 6: reset mid-transfer, then interrupts
        CSR_kb_i = 8'h10;
        cpu_push(8'h66, 1);
        wait_send();
        dev_write(8'h99, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        kb_exp.delete();
        tx_exp.delete();
        chk("rst_mid_control", {30'd0, control_o}, 32'h3);
        chk("rst_mid_bus", {24'd0, data_bus_o}, 32'h00);
        chk("rst_mid_kb_empty", {24'd0, CSR_kb_o}, 32'h10);
        chk("rst_mid_scr_empty", {24'd0, CSR_scr_o}, 32'h14);
        tick();
        chk("rst_mid_stays_idle", {30'd0, control_o}, 32'h3);
        CSR_kb_i = 8'h11; CSR_scr_i = 8'h11;
        dev_write(8'h5A, 1);
`ifdef KB_SCR_IRQ_EN
        chk("kb_irq_on", {31'd0, kb_irq}, 32'd1);
        chk("scr_irq_on", {31'd0, scr_irq}, 32'd1);
`else
        chk("kb_irq_off", {31'd0, kb_irq}, 32'd0);
        chk("scr_irq_off", {31'd0, scr_irq}, 32'd0);
`endif
        cpu_pop();
        tick();

        chk("kb_queue_drained", kb_exp.size(), 32'd0);
        chk("tx_queue_drained", tx_exp.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
